return_stack: RTL
=================

# return_stack

Parametrised return-address stack for the CPU's call/return path. It holds up to DEPTH entries of WIDTH bits and shows the most recently pushed entry combinationally on `top`. Compared with the fixed 12-bit, 8-entry version, it adds:
- occupancy count, full and empty flags;
- a single-cycle replace-top operation;
- synchronous flush;
- sticky overflow and underflow error flags;
- a selectable overflow policy.

State updates on the falling edge of `clk`, so the posedge-sampled datapath sees a stable `top`.

## Interface
- `WIDTH`, default 12: entry (address) width in bits.
- `DEPTH`, default 8: number of entries. Must be a power of two and ≥ 2.
- `OVF_MODE`, default 0: overflow policy. 0 = reject a push when full. 1 = circular, the push overwrites the oldest entry.
- `clk`, input, 1: clock. All state changes on negedge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `push`, input, 1: push `push_data`.
- `pop`, input, 1: discard the top entry.
- `flush`, input, 1: synchronous clear of the contents.
- `clear_err`, input, 1: clear the sticky error flags.
- `push_data`, input, WIDTH: entry to push.
- `top`, output, WIDTH: most recently pushed valid entry. 0 when empty.
- `count`, output, $clog2(DEPTH+1): number of valid entries, 0..DEPTH.
- `full`, output, 1: high when `count == DEPTH`.
- `empty`, output, 1: high when `count == 0`.
- `overflow`, output, 1: sticky. Set by a push while full.
- `underflow`, output, 1: sticky. Set by a pop while empty.

## Operation
**Storage**
- DEPTH x WIDTH register array, not reset.
- Write pointer `wp` is $clog2(DEPTH) bits and wraps modulo DEPTH.
- Top slot is `wp-1` (mod DEPTH).
- `top = empty ? 0 : mem[wp-1]`. Purely combinational from registered state.

**Per-negedge priority**
1. `flush`: `wp=0`, `count=0`. Ignores `push` and `pop`. Error flags are unchanged unless `clear_err` is also high.
2. `push` & `pop`, not empty: replace top. Write `mem[wp-1] = push_data`. `wp` and `count` unchanged.
3. `push` & `pop`, empty: behaves as a push. `mem[0]` written, `count=1`, and `underflow` is set.
4. `push` only, not full: `mem[wp] = push_data`, `wp+1`, `count+1`.
5. `push` only, full, `OVF_MODE=0`: no state change, `overflow` set.
6. `push` only, full, `OVF_MODE=1`: `mem[wp] = push_data` overwrites the oldest entry. `wp+1`, `count` stays DEPTH, `overflow` set.
7. `pop` only, not empty: `wp-1`, `count-1`. Memory is not cleared.
8. `pop` only, empty: no state change, `underflow` set.

**Error flags**
- `clear_err` clears both flags on the same edge.
- If a set event and `clear_err` occur on the same edge, set wins.

**Flags and width**
- `full` and `empty` decode from `count` only.
- `count` never exceeds DEPTH and never goes below 0.
- There is no arithmetic on entry data. Entries pass through at full WIDTH.

## Timing
- Reset, asynchronous and immediate on `rst_n` low:
  - `wp=0`, `count=0`, `empty=1`, `full=0`, `top=0`, `overflow=0`, `underflow=0`.
- Release of `rst_n` takes effect at the next negedge. Inputs are ignored while `rst_n` is low.
- Reset asserted mid-sequence discards all entries.
- Latency: a push on negedge N is visible on `top`, `count` and the flags immediately after negedge N. They are stable for the following posedge.
- Pop latency is the same: the new top is visible after the same edge.
- Inputs are sampled on negedge. They must be stable around the falling edge; they are launched from posedge logic.
- One operation per cycle. No handshake and no stall; the caller checks `full`/`empty` or the error flags.
- Wrap-around in `OVF_MODE=1`: after DEPTH+k pushes, `top` is the last push. Popping DEPTH times then yields only the newest DEPTH values, and `empty` rises after the DEPTH-th pop.

## Test plan
All scenarios use WIDTH=12, DEPTH=8.

1. **Reset and empty pop.** Reset, then pulse `pop` once. Expect `count=0`, `empty=1`, `top=0`, `underflow=1`. Then pulse `clear_err`; expect `underflow=0`.
2. **LIFO order.** Push 0x101..0x108. Expect `full=1`, `count=8`, `top=0x108`. Pop 8 times; expect `top` to read 0x107..0x101, then 0, with `empty=1` after the last pop.
3. **Reject on full (OVF_MODE=0).** Fill to 8 entries, then push 0xABC. Expect `overflow=1`, `count=8`, `top=0x108`. Popping all 8 returns the original values.
4. **Circular overwrite (OVF_MODE=1).** Push 0x001..0x00A (10 pushes). Expect `count=8`, `top=0x00A`, `overflow=1`. Eight pops read 0x009..0x003 on `top`, then `empty=1`.
5. **Replace top.** Push 0x111, 0x222, then assert `push` and `pop` together with 0x333. Expect `count=2`, `top=0x333`. One pop gives `top=0x111`. Push and pop together while empty with 0x044: expect `count=1`, `top=0x044`, `underflow=1`.
6. **Flush and mid-operation reset.** Push 3 entries, then assert `flush` together with `push`. Expect `count=0`, `top=0`, and the push ignored. Push 2 entries, then drop `rst_n` between edges. Expect `count=0`, `top=0` asynchronously, before the next edge.

Source files
------------

// File: rtl/return_stack.sv
// return_stack
//   LIFO of return addresses for the call/return path. The most recently
//   pushed entry is shown combinationally on `top`. All state changes happen
//   on the falling edge of clk, so logic that samples on the rising edge
//   always sees a settled `top`.
//
// Parameters
//   WIDTH     entry width in bits
//   DEPTH     number of entries (power of two, >= 2)
//   OVF_MODE  0: a push while full is rejected
//             1: a push while full overwrites the oldest entry
//
// Ports
//   clk        clock, state updates on negedge
//   rst_n      asynchronous active-low reset
//   push       push push_data
//   pop        discard the top entry (push+pop together replaces the top)
//   flush      synchronous clear of the contents
//   clear_err  clear the sticky overflow/underflow flags
//   push_data  entry to push
//   top        most recent valid entry, 0 when empty
//   count      number of valid entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky: push while full
//   underflow  sticky: pop while empty
module return_stack #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned OVF_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       clear_err,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_FLUSH,
    OP_REPLACE,
    OP_PUSH_EMPTY,
    OP_PUSH,
    OP_PUSH_FULL,
    OP_POP,
    OP_POP_EMPTY
  } op_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    top_idx;

  op_t              op;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [AW-1:0]    wp_nxt;
  logic [CW-1:0]    count_nxt;
  logic             ovf_evt;
  logic             unf_evt;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign top_idx = wp - AW'(1);
  assign top     = empty ? '0 : mem[top_idx];

  // Operation decode in priority order.
  always_comb begin
    op = OP_IDLE;
    if (flush) begin
      op = OP_FLUSH;
    end else if (push && pop) begin
      op = empty ? OP_PUSH_EMPTY : OP_REPLACE;
    end else if (push) begin
      op = full ? OP_PUSH_FULL : OP_PUSH;
    end else if (pop) begin
      op = empty ? OP_POP_EMPTY : OP_POP;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_wa    = wp;
    wp_nxt    = wp;
    count_nxt = count;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    unique case (op)
      OP_FLUSH: begin
        wp_nxt    = '0;
        count_nxt = '0;
      end
      OP_REPLACE: begin
        mem_we = 1'b1;
        mem_wa = top_idx;
      end
      // After circular wrap the pointer need not be 0 when empty; the entry
      // is forced into slot 0 and wp re-based so that top reads it back.
      OP_PUSH_EMPTY: begin
        mem_we    = 1'b1;
        mem_wa    = '0;
        wp_nxt    = AW'(1);
        count_nxt = CW'(1);
        unf_evt   = 1'b1;
      end
      OP_PUSH: begin
        mem_we    = 1'b1;
        wp_nxt    = wp + AW'(1);
        count_nxt = count + CW'(1);
      end
      OP_PUSH_FULL: begin
        ovf_evt = 1'b1;
        if (OVF_MODE != 0) begin
          // wp already points at the oldest slot when full.
          mem_we = 1'b1;
          wp_nxt = wp + AW'(1);
        end
      end
      OP_POP: begin
        wp_nxt    = wp - AW'(1);
        count_nxt = count - CW'(1);
      end
      OP_POP_EMPTY: begin
        unf_evt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp        <= wp_nxt;
      count     <= count_nxt;
      // A new error event on the same edge as clear_err wins.
      overflow  <= ovf_evt | (overflow  & ~clear_err);
      underflow <= unf_evt | (underflow & ~clear_err);
    end
  end

  // Storage is not reset; writes are blocked while reset is held.
  always_ff @(negedge clk) begin
    if (mem_we && rst_n) begin
      mem[mem_wa] <= push_data;
    end
  end

endmodule
